// File: rtl/elevator_pkg.sv
// Shared types and constants for the three-floor elevator controller.
// Optional feature macro: ELEVATOR_REQ_LATCH_EN (sticky floor-call latching).
package elevator_pkg;

  localparam int DEF_NUM_FLOORS  = 3;
  localparam int DEF_DOOR_CYCLES = 2;
  localparam int FLOOR_W         = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

endpackage

// File: rtl/elevator_req_tracker.sv
// Floor-call tracker: forms the effective call set and reports calls at,
// above and below a probe floor. With ELEVATOR_REQ_LATCH_EN defined, calls
// are held in a sticky pending register until the car serves them;
// otherwise the call set is simply the live request level.
module elevator_req_tracker
  import elevator_pkg::*;
(
`ifdef ELEVATOR_REQ_LATCH_EN
  input  logic               clk,
  input  logic               reset,
`endif
  input  logic [2:0]         req,
  input  logic [FLOOR_W-1:0] floor,
  output logic               call_here,
  output logic               call_above,
  output logic               call_below
);

  logic [2:0] pend_eff;

`ifdef ELEVATOR_REQ_LATCH_EN
  logic [2:0] pending;
  logic [2:0] served;

  assign pend_eff = pending | req;

  // The floor being served is dropped, even if requested again this cycle
  always_comb begin
    served = '0;
    for (int i = 0; i < 3; i++) begin
      served[i] = call_here && (floor == FLOOR_W'(i));
    end
  end

  // Sticky call register
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pend_eff & ~served;
    end
  end
`else
  assign pend_eff = req;
`endif

  // Classify the call set relative to the probe floor
  always_comb begin
    call_here  = 1'b0;
    call_above = 1'b0;
    call_below = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (FLOOR_W'(i) == floor) call_here  = call_here  | pend_eff[i];
      if (FLOOR_W'(i) >  floor) call_above = call_above | pend_eff[i];
      if (FLOOR_W'(i) <  floor) call_below = call_below | pend_eff[i];
    end
  end

endmodule

// File: rtl/elevator_controller.sv
// Three-floor elevator car controller with SCAN scheduling.
// The car steps one floor per clock toward pending calls, keeps its sweep
// direction while calls remain ahead, and holds the door open for
// DOOR_CYCLES clocks at each served floor.
// Optional feature macro: ELEVATOR_REQ_LATCH_EN (sticky floor-call latching).
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  output logic [1:0] current_floor,
  output logic       direction,
  output logic       door
);

  localparam int                   DWELL_W    = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [DWELL_W-1:0]   DWELL_LOAD = DWELL_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0]   TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

  state_t               state;
  logic [DWELL_W-1:0]   dwell;
  logic                 step_up;
  logic                 sweep_dir;
  logic [FLOOR_W-1:0]   next_floor;
  logic [FLOOR_W-1:0]   probe_floor;
  logic                 call_here;
  logic                 call_above;
  logic                 call_below;

  // Step direction clamped at the shaft ends, the floor the car would reach,
  // and the floor whose calls matter this cycle (arrival floor when moving)
  always_comb begin
    step_up = direction;
    if (current_floor == '0) begin
      step_up = 1'b1;
    end else if (current_floor == TOP_FLOOR) begin
      step_up = 1'b0;
    end
    next_floor  = step_up ? current_floor + FLOOR_W'(1) : current_floor - FLOOR_W'(1);
    probe_floor = (state == MOVE) ? next_floor : current_floor;
    // keep sweeping while calls lie ahead, otherwise turn toward the rest
    sweep_dir   = step_up ? call_above : ~call_below;
  end

  elevator_req_tracker u_req_tracker (
`ifdef ELEVATOR_REQ_LATCH_EN
    .clk        (clk),
    .reset      (reset),
`endif
    .req        (req),
    .floor      (probe_floor),
    .call_here  (call_here),
    .call_above (call_above),
    .call_below (call_below)
  );

  // Car FSM with position, direction, door and dwell registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      current_floor <= '0;
      direction     <= 1'b0;
      door          <= 1'b0;
      dwell         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (call_here) begin
            state <= DOOR;
            door  <= 1'b1;
            dwell <= DWELL_LOAD;
          end else if (call_above || call_below) begin
            state     <= MOVE;
            direction <= sweep_dir;
          end
        end
        MOVE: begin
          current_floor <= next_floor;
          if (call_here) begin
            state <= DOOR;
            door  <= 1'b1;
            dwell <= DWELL_LOAD;
          end else if (!call_above && !call_below) begin
            state <= IDLE;
          end else begin
            direction <= sweep_dir;
          end
        end
        DOOR: begin
          if (call_here) begin
            dwell <= DWELL_LOAD;
          end else if (dwell == '0) begin
            state <= IDLE;
            door  <= 1'b0;
          end else begin
            dwell <= dwell - DWELL_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          door  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_controller.sv
// Self-checking bench for elevator_controller: a directed vector table,
// a hand-written single-pulse sequence, and randomized traffic checked
// against a floor/call-set reference model.
module tb_elevator_controller;

  localparam int DC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [1:0] current_floor;
  logic       direction;
  logic       door;

  int total = 0;
  int bad   = 0;

  elevator_controller dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .current_floor (current_floor),
    .direction     (direction),
    .door          (door)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic [2:0] rq;
    logic [1:0] f;
    logic       d;
    logic       dr;
  } vec_t;

  vec_t tbl[32];

  // reference model: car position, sweep direction, door time left, call set
  int  m_floor;
  bit  m_dir;
  int  m_door_left;
  bit  m_moving;
`ifdef ELEVATOR_REQ_LATCH_EN
  bit [2:0] m_calls;
`endif

  function automatic bit any_above(input bit [2:0] s, input int f);
    for (int g = f + 1; g < 3; g++) if (s[g]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(input bit [2:0] s, input int f);
    for (int g = 0; g < f; g++) if (s[g]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_dir = 1'b0; m_door_left = 0; m_moving = 1'b0;
`ifdef ELEVATOR_REQ_LATCH_EN
    m_calls = '0;
`endif
  endtask

  task automatic model_step(input logic [2:0] q);
    bit [2:0] eff;
`ifdef ELEVATOR_REQ_LATCH_EN
    eff = m_calls | q;
`else
    eff = q;
`endif
    if (m_door_left > 0) begin
      if (eff[m_floor]) begin
        m_door_left = DC;
        eff[m_floor] = 1'b0;
      end else begin
        m_door_left--;
      end
    end else if (m_moving) begin
      m_floor = m_dir ? m_floor + 1 : m_floor - 1;
      if (eff[m_floor]) begin
        m_door_left = DC;
        eff[m_floor] = 1'b0;
        m_moving = 1'b0;
      end else if (eff == 0) begin
        m_moving = 1'b0;
      end else if (m_dir ? !any_above(eff, m_floor) : !any_below(eff, m_floor)) begin
        m_dir = !m_dir;
      end
    end else if (eff != 0) begin
      if (eff[m_floor]) begin
        m_door_left = DC;
        eff[m_floor] = 1'b0;
      end else begin
        if (m_dir ? !any_above(eff, m_floor) : !any_below(eff, m_floor)) m_dir = !m_dir;
        m_moving = 1'b1;
      end
    end
`ifdef ELEVATOR_REQ_LATCH_EN
    m_calls = eff;
`endif
  endtask

  task automatic tick(input logic r, input logic [2:0] q);
    reset = r;
    req   = q;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] ef, input logic ed, input logic edr);
    total++;
    if (current_floor !== ef || direction !== ed || door !== edr) begin
      bad++;
      $display("FAIL %s: got floor=%0d dir=%0b door=%0b, want floor=%0d dir=%0b door=%0b",
               name, current_floor, direction, door, ef, ed, edr);
    end
  endtask

  initial begin
    logic       r;
    logic [2:0] q;
    logic [1:0] pf[7];
    logic       pd[7];
    logic       pdr[7];

    reset = 1'b1;
    req   = 3'b000;

    //            rst   req     floor dir door
    tbl[0]  = '{1'b1, 3'b000, 2'd0, 1'b0, 1'b0}; // reset
    tbl[1]  = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 3'b100, 2'd0, 1'b1, 1'b0}; // leave IDLE upward
    tbl[4]  = '{1'b0, 3'b100, 2'd1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 3'b100, 2'd2, 1'b1, 1'b1}; // arrive, door opens
    tbl[6]  = '{1'b0, 3'b000, 2'd2, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 3'b000, 2'd2, 1'b1, 1'b0}; // door closes
    tbl[8]  = '{1'b0, 3'b000, 2'd2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 3'b001, 2'd2, 1'b0, 1'b0}; // leave floor 2 downward
    tbl[10] = '{1'b0, 3'b001, 2'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 3'b001, 2'd0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 3'b001, 2'd0, 1'b0, 1'b1}; // call at own floor
    tbl[15] = '{1'b0, 3'b001, 2'd0, 1'b0, 1'b1}; // repeat call extends dwell
    tbl[16] = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 3'b100, 2'd0, 1'b1, 1'b0}; // SCAN: head up
    tbl[19] = '{1'b0, 3'b100, 2'd1, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 3'b101, 2'd2, 1'b1, 1'b1}; // floor 2 first
    tbl[21] = '{1'b0, 3'b001, 2'd2, 1'b1, 1'b1};
    tbl[22] = '{1'b0, 3'b001, 2'd2, 1'b1, 1'b0};
    tbl[23] = '{1'b0, 3'b001, 2'd2, 1'b0, 1'b0}; // reverse toward floor 0
    tbl[24] = '{1'b0, 3'b001, 2'd1, 1'b0, 1'b0};
    tbl[25] = '{1'b0, 3'b001, 2'd0, 1'b0, 1'b1};
    tbl[26] = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b1};
    tbl[27] = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
    tbl[28] = '{1'b0, 3'b100, 2'd0, 1'b1, 1'b0};
    tbl[29] = '{1'b0, 3'b000, 2'd1, 1'b1, 1'b0};
    tbl[30] = '{1'b1, 3'b000, 2'd0, 1'b0, 1'b0}; // reset mid-move
    tbl[31] = '{1'b0, 3'b000, 2'd0, 1'b0, 1'b0}; // nothing left pending

    for (int i = 0; i < 32; i++) begin
      tick(tbl[i].rst, tbl[i].rq);
      check($sformatf("vec%0d", i), tbl[i].f, tbl[i].d, tbl[i].dr);
    end

    // single-cycle call pulse for floor 2 from an idle car at floor 0
`ifdef ELEVATOR_REQ_LATCH_EN
    pf  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    pd  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    pdr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    pf  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    pd  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    pdr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, (i == 0) ? 3'b100 : 3'b000);
      check($sformatf("pulse%0d", i), pf[i], pd[i], pdr[i]);
    end

    // randomized traffic against the reference model
    tick(1'b1, 3'b000);
    model_reset();
    check("rand_reset", 2'd0, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(199) == 0);
      for (int b = 0; b < 3; b++) q[b] = ($urandom_range(3) == 0);
      if ($urandom_range(3) == 0) q = 3'b000;
      tick(r, q);
      if (r) model_reset();
      else   model_step(q);
      check($sformatf("rand%0d", c), 2'(m_floor), m_dir, (m_door_left > 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
